// File: rtl/fifo1w2r_pkg.sv
// Shared constants and pointer helpers for the one-writer / two-reader
// broadcast FIFO controller.
//   ADDRBIT_DEF : default RAM address width (DEPTH_DEF = 2**ADDRBIT_DEF entries)
//   ptr_width   : pointer width for a given address width (one extra wrap bit)
//   ptr_dist    : modular distance a-b over a pointer of width pw
package fifo1w2r_pkg;

  localparam int ADDRBIT_DEF = 9;
  localparam int WIDTH_DEF   = 32;

  function automatic int ptr_width(input int addrbit);
    return addrbit + 1;
  endfunction

  // Pointers are carried zero-extended in 32 bits; the mask keeps the
  // subtraction modulo 2**pw so wrapped pointers still give 0..DEPTH.
  function automatic logic [31:0] ptr_dist(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          pw);
    logic [31:0] mask;
    mask = (pw >= 32) ? '1 : ((32'd1 << pw) - 32'd1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/fifo1w2r_ctrl_if.sv
// Bus bundle between the broadcast FIFO controller and its environment.
//   writer : wr_req, wr_data -> ; <- full, ovf
//   reader n (n=1,2) : rdn_req -> ; <- rdn_vld, rdn_data, emptyn, udfn, lvln
//   memory : <- mwa, mwe, mdi (write port), mran, mren (read ports); mdon ->
// Modport slave is the controller, master is the surrounding system
// (writer, both readers and the 2R1W RAM).
interface fifo1w2r_ctrl_if
  import fifo1w2r_pkg::*;
#(
  parameter int ADDRBIT = ADDRBIT_DEF,
  parameter int WIDTH   = WIDTH_DEF
);

  logic               wr_req;
  logic [WIDTH-1:0]   wr_data;
  logic               full;
  logic               ovf;

  logic               rd1_req;
  logic               rd1_vld;
  logic [WIDTH-1:0]   rd1_data;
  logic               empty1;
  logic               udf1;
  logic [ADDRBIT:0]   lvl1;

  logic               rd2_req;
  logic               rd2_vld;
  logic [WIDTH-1:0]   rd2_data;
  logic               empty2;
  logic               udf2;
  logic [ADDRBIT:0]   lvl2;

  logic [ADDRBIT-1:0] mwa;
  logic               mwe;
  logic [WIDTH-1:0]   mdi;
  logic [ADDRBIT-1:0] mra1;
  logic               mre1;
  logic [WIDTH-1:0]   mdo1;
  logic [ADDRBIT-1:0] mra2;
  logic               mre2;
  logic [WIDTH-1:0]   mdo2;

  modport slave (
    input  wr_req, wr_data, rd1_req, rd2_req, mdo1, mdo2,
    output full, ovf,
    output rd1_vld, rd1_data, empty1, udf1, lvl1,
    output rd2_vld, rd2_data, empty2, udf2, lvl2,
    output mwa, mwe, mdi, mra1, mre1, mra2, mre2
  );

  modport master (
    output wr_req, wr_data, rd1_req, rd2_req, mdo1, mdo2,
    input  full, ovf,
    input  rd1_vld, rd1_data, empty1, udf1, lvl1,
    input  rd2_vld, rd2_data, empty2, udf2, lvl2,
    input  mwa, mwe, mdi, mra1, mre1, mra2, mre2
  );

endinterface

// File: rtl/fifo1w2r_rdport.sv
// One reader of the broadcast FIFO: read pointer, empty flag, sticky
// underflow, read-data qualifier and (optionally) the occupancy level.
// Build option: FIFO1W2R_LEVEL_EN registers lvl = wp - rp; without it lvl
// is tied to 0 and the subtractor disappears.
// Ports:
//   clk, rst_ : clock, async active-low reset
//   wp_nxt    : writer pointer as it will be after this edge
//   rd_req    : pop request
//   rp_nxt    : this reader's pointer as it will be after this edge
//   empty, udf, vld, lvl : reader status (vld trails an accepted pop by 1)
//   mra, mre  : RAM read address / enable
module fifo1w2r_rdport
  import fifo1w2r_pkg::*;
#(
  parameter int ADDRBIT = ADDRBIT_DEF
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [ADDRBIT:0]   wp_nxt,
  input  logic               rd_req,
  output logic [ADDRBIT:0]   rp_nxt,
  output logic               empty,
  output logic               udf,
  output logic               vld,
  output logic [ADDRBIT:0]   lvl,
  output logic [ADDRBIT-1:0] mra,
  output logic               mre
);

  logic [ADDRBIT:0] rp_q;
  logic             empty_q;
  logic             udf_q;
  logic             vld_q;
  logic             pop_ok;

  always_comb begin
    pop_ok = rd_req & ~empty_q;
    rp_nxt = rp_q + {{ADDRBIT{1'b0}}, pop_ok};
  end

  // Flags are computed from the post-edge pointers so the registered
  // value always describes the state the pointers are in.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rp_q    <= '0;
      empty_q <= 1'b1;
      udf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      rp_q    <= rp_nxt;
      empty_q <= (wp_nxt == rp_nxt);
      udf_q   <= udf_q | (rd_req & empty_q);
      vld_q   <= pop_ok;
    end
  end

`ifdef FIFO1W2R_LEVEL_EN
  localparam int PW = ptr_width(ADDRBIT);
  logic [ADDRBIT:0] lvl_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) lvl_q <= '0;
    else       lvl_q <= PW'(ptr_dist(32'(wp_nxt), 32'(rp_nxt), PW));
  end

  assign lvl = lvl_q;
`else
  assign lvl = '0;
`endif

  assign empty = empty_q;
  assign udf   = udf_q;
  assign vld   = vld_q;
  assign mre   = pop_ok;
  assign mra   = rp_q[ADDRBIT-1:0];

endmodule

// File: rtl/fifo1w2r_ctrl.sv
// Broadcast FIFO controller: one writer, two independent readers sharing
// a 2R1W RAM. Every accepted word is delivered once to each reader in push
// order; the slower reader throttles the writer through full.
// Build option: FIFO1W2R_LEVEL_EN enables the per-reader lvl registers.
// Ports:
//   clk  : clock, rising edge
//   rst_ : async active-low reset
//   bus  : fifo1w2r_ctrl_if.slave (writer, two readers, RAM side)
// Parameters: ADDRBIT (address width), DEPTH (= 2**ADDRBIT), WIDTH (data).
module fifo1w2r_ctrl
  import fifo1w2r_pkg::*;
#(
  parameter int ADDRBIT = ADDRBIT_DEF,
  parameter int DEPTH   = 2 ** ADDRBIT,
  parameter int WIDTH   = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst_,
  fifo1w2r_ctrl_if.slave bus
);

  localparam int PW = ptr_width(ADDRBIT);

  logic [ADDRBIT:0] wp_q;
  logic [ADDRBIT:0] wp_nxt;
  logic [ADDRBIT:0] rp1_nxt;
  logic [ADDRBIT:0] rp2_nxt;
  logic             full_q;
  logic             full_nxt;
  logic             ovf_q;
  logic             push_ok;
  logic [WIDTH-1:0] wdat;

  always_comb begin
    push_ok  = bus.wr_req & ~full_q;
    wp_nxt   = wp_q + {{ADDRBIT{1'b0}}, push_ok};
    full_nxt = (ptr_dist(32'(wp_nxt), 32'(rp1_nxt), PW) == 32'(DEPTH)) ||
               (ptr_dist(32'(wp_nxt), 32'(rp2_nxt), PW) == 32'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wp_q   <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wp_q   <= wp_nxt;
      full_q <= full_nxt;
      ovf_q  <= ovf_q | (bus.wr_req & full_q);
    end
  end

  assign wdat     = bus.wr_data;
  assign bus.mwe  = push_ok;
  assign bus.mwa  = wp_q[ADDRBIT-1:0];
  assign bus.mdi  = wdat;
  assign bus.full = full_q;
  assign bus.ovf  = ovf_q;

  // RAM read data is registered inside the RAM, so it lines up with vld.
  assign bus.rd1_data = bus.mdo1;
  assign bus.rd2_data = bus.mdo2;

  fifo1w2r_rdport #(.ADDRBIT(ADDRBIT)) u_rd1 (
    .clk    (clk),
    .rst_   (rst_),
    .wp_nxt (wp_nxt),
    .rd_req (bus.rd1_req),
    .rp_nxt (rp1_nxt),
    .empty  (bus.empty1),
    .udf    (bus.udf1),
    .vld    (bus.rd1_vld),
    .lvl    (bus.lvl1),
    .mra    (bus.mra1),
    .mre    (bus.mre1)
  );

  fifo1w2r_rdport #(.ADDRBIT(ADDRBIT)) u_rd2 (
    .clk    (clk),
    .rst_   (rst_),
    .wp_nxt (wp_nxt),
    .rd_req (bus.rd2_req),
    .rp_nxt (rp2_nxt),
    .empty  (bus.empty2),
    .udf    (bus.udf2),
    .vld    (bus.rd2_vld),
    .lvl    (bus.lvl2),
    .mra    (bus.mra2),
    .mre    (bus.mre2)
  );

endmodule

// File: tb/tb_fifo1w2r_ctrl.sv
// Directed bench for fifo1w2r_ctrl with a behavioural 2R1W RAM.
module tb_fifo1w2r_ctrl;

  localparam int AB = 9;
  localparam int DP = 512;
  localparam int WD = 32;

`ifdef FIFO1W2R_LEVEL_EN
  localparam bit LVL_ON = 1'b1;
`else
  localparam bit LVL_ON = 1'b0;
`endif

  logic clk;
  logic rst_;
  int   checks;
  int   errors;

  logic [WD-1:0] mem [0:DP-1];
  logic [WD-1:0] a_dat [0:2];
  int            q1 [$];
  int            q2 [$];

  fifo1w2r_ctrl_if #(.ADDRBIT(AB), .WIDTH(WD)) bus ();

  fifo1w2r_ctrl #(.ADDRBIT(AB), .DEPTH(DP), .WIDTH(WD)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mwe)  mem[bus.mwa] <= bus.mdi;
    if (bus.mre1) bus.mdo1 <= mem[bus.mra1];
    if (bus.mre2) bus.mdo2 <= mem[bus.mra2];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wr_req  = 1'b0;
    bus.wr_data = '0;
    bus.rd1_req = 1'b0;
    bus.rd2_req = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_ = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_full"},   bus.full,    1'b0);
    check({tag, "_ovf"},    bus.ovf,     1'b0);
    check({tag, "_empty1"}, bus.empty1,  1'b1);
    check({tag, "_empty2"}, bus.empty2,  1'b1);
    check({tag, "_udf1"},   bus.udf1,    1'b0);
    check({tag, "_udf2"},   bus.udf2,    1'b0);
    check({tag, "_vld1"},   bus.rd1_vld, 1'b0);
    check({tag, "_vld2"},   bus.rd2_vld, 1'b0);
    check({tag, "_lvl1"},   bus.lvl1,    '0);
    check({tag, "_lvl2"},   bus.lvl2,    '0);
  endtask

  initial begin
    int  k, e1, e2, n1, n2;
    bit  pv1, pv2, p1, p2, push_ok;

    checks = 0;
    errors = 0;
    a_dat[0] = 32'h11;
    a_dat[1] = 32'h22;
    a_dat[2] = 32'h33;
    idle();
    rst_ = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_cleared("rst");
    rst_ = 1'b1;
    @(negedge clk);

    // three pushes, both readers see them
    for (int i = 0; i < 3; i++) begin
      bus.wr_req  = 1'b1;
      bus.wr_data = a_dat[i];
      #1;
      check("a_mwe", bus.mwe, 1'b1);
      check("a_mwa", bus.mwa, 64'(i));
      check("a_mdi", bus.mdi, a_dat[i]);
      @(negedge clk);
    end
    idle();
    check("a_empty1", bus.empty1, 1'b0);
    check("a_empty2", bus.empty2, 1'b0);
    check("a_lvl2",   bus.lvl2, LVL_ON ? 64'd3 : 64'd0);

    // reader1 pops all three, data one cycle after each request
    for (int i = 0; i < 3; i++) begin
      bus.rd1_req = 1'b1;
      #1;
      check("a_mre1", bus.mre1, 1'b1);
      check("a_mra1", bus.mra1, 64'(i));
      @(negedge clk);
      check("a_vld1",  bus.rd1_vld,  1'b1);
      check("a_data1", bus.rd1_data, a_dat[i]);
    end
    idle();
    check("a_empty1_done", bus.empty1, 1'b1);
    @(negedge clk);
    check("a_vld1_off", bus.rd1_vld, 1'b0);
    check("a_empty2_kept", bus.empty2, 1'b0);
    check("a_lvl2_kept", bus.lvl2, LVL_ON ? 64'd3 : 64'd0);
    check("a_lvl1_zero", bus.lvl1, '0);

    // pop reader2 while empty
    do_reset();
    bus.rd2_req = 1'b1;
    #1;
    check("d_mre2", bus.mre2, 1'b0);
    @(negedge clk);
    idle();
    check("d_udf2", bus.udf2, 1'b1);
    check("d_vld2", bus.rd2_vld, 1'b0);
    check("d_udf1", bus.udf1, 1'b0);
    @(negedge clk);
    check("d_vld2_later", bus.rd2_vld, 1'b0);

    // push into empty plus pop: pop rejected, push accepted
    bus.wr_req  = 1'b1;
    bus.wr_data = 32'h55;
    bus.rd1_req = 1'b1;
    #1;
    check("e_mwe",  bus.mwe,  1'b1);
    check("e_mre1", bus.mre1, 1'b0);
    @(negedge clk);
    idle();
    check("e_udf1",   bus.udf1,    1'b1);
    check("e_empty1", bus.empty1,  1'b0);
    check("e_vld1",   bus.rd1_vld, 1'b0);

    // fill to DEPTH, then overflow
    do_reset();
    for (int i = 0; i < DP; i++) begin
      bus.wr_req  = 1'b1;
      bus.wr_data = 32'(i);
      if (i == DP - 1) check("b_full_before", bus.full, 1'b0);
      @(negedge clk);
    end
    check("b_full", bus.full, 1'b1);
    check("b_ovf_before", bus.ovf, 1'b0);
    bus.wr_data = 32'hdead;
    #1;
    check("b_mwe_rej", bus.mwe, 1'b0);
    @(negedge clk);
    idle();
    check("b_ovf", bus.ovf, 1'b1);
    check("b_lvl1", bus.lvl1, LVL_ON ? 64'd512 : 64'd0);

    // reader1 drains; reader2 still holds the writer off
    for (int i = 0; i < DP; i++) begin
      bus.rd1_req = 1'b1;
      @(negedge clk);
      check("c_vld1",  bus.rd1_vld,  1'b1);
      check("c_data1", bus.rd1_data, 64'(i));
    end
    idle();
    check("c_empty1", bus.empty1, 1'b1);
    check("c_full_held", bus.full, 1'b1);
    @(negedge clk);
    check("c_full_held2", bus.full, 1'b1);
    check("c_udf1", bus.udf1, 1'b0);

    // reader2 pops once while writer pushes: push rejected against old full
    bus.wr_req  = 1'b1;
    bus.wr_data = 32'haa;
    bus.rd2_req = 1'b1;
    #1;
    check("c_mwe_rej", bus.mwe,  1'b0);
    check("c_mre2",    bus.mre2, 1'b1);
    check("c_mra2",    bus.mra2, '0);
    @(negedge clk);
    idle();
    check("c_full_clear",  bus.full,     1'b0);
    check("c_empty1_kept", bus.empty1,   1'b1);
    check("c_vld2",        bus.rd2_vld,  1'b1);
    check("c_data2",       bus.rd2_data, '0);

    // sustained streaming, reader2 skips every 5th slot
    do_reset();
    q1.delete();
    q2.delete();
    k = 0; pv1 = 0; pv2 = 0; n1 = 0; n2 = 0; e1 = 0; e2 = 0;
    for (int c = 0; c < 2000; c++) begin
      check("s_vld1", bus.rd1_vld, pv1);
      check("s_vld2", bus.rd2_vld, pv2);
      if (bus.rd1_vld) n1++;
      if (bus.rd2_vld) n2++;
      if (pv1) check("s_data1", bus.rd1_data, 64'(e1));
      if (pv2) check("s_data2", bus.rd2_data, 64'(e2));
      bus.wr_req  = 1'b1;
      bus.wr_data = 32'(k);
      bus.rd1_req = 1'b1;
      bus.rd2_req = ((c % 5) != 3);
      push_ok = (q1.size() < DP) && (q2.size() < DP);
      p1 = (q1.size() != 0);
      p2 = bus.rd2_req && (q2.size() != 0);
      if (p1) e1 = q1.pop_front();
      if (p2) e2 = q2.pop_front();
      if (push_ok) begin
        q1.push_back(k);
        q2.push_back(k);
        k++;
      end
      pv1 = p1;
      pv2 = p2;
      @(negedge clk);
    end
    check("s_vld1_last", bus.rd1_vld, pv1);
    check("s_vld2_last", bus.rd2_vld, pv2);
    if (bus.rd1_vld) n1++;
    if (bus.rd2_vld) n2++;
    if (pv1) check("s_data1_last", bus.rd1_data, 64'(e1));
    if (pv2) check("s_data2_last", bus.rd2_data, 64'(e2));
    check("s_count1", 64'(n1), 64'd1999);
    check("s_count2", 64'(n2), 64'd1599);

    // reset mid-stream with a read in flight
    bus.wr_req  = 1'b1;
    bus.wr_data = 32'hbeef;
    bus.rd1_req = 1'b1;
    bus.rd2_req = 1'b1;
    @(posedge clk);
    #2;
    check("r_vld1_pre",  bus.rd1_vld, 1'b1);
    check("r_udf1_pre",  bus.udf1,    1'b1);
    check("r_empty2_pre", bus.empty2, 1'b0);
    rst_ = 1'b0;
    #1;
    check_cleared("r");
    idle();
    @(negedge clk);
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    check("r_vld1_after", bus.rd1_vld, 1'b0);
    check("r_vld2_after", bus.rd2_vld, 1'b0);
    check("r_empty1_after", bus.empty1, 1'b1);
    @(negedge clk);
    check("r_vld1_after2", bus.rd1_vld, 1'b0);
    check("r_empty2_after", bus.empty2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
